instr_fetch_mem: RTL

INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

---
 rtl/instr_fetch_mem.sv | 138 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_mem.sv
// Instruction memory with LOAD/RUN modes and a 2-entry fetch response FIFO.
// Optional per-word even parity with an rsp_perr output when IMEM_PARITY_EN is defined.
module instr_fetch_mem #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              halt,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_oob,
  input  logic              rsp_ready,
  output logic              mode_run
`ifdef IMEM_PARITY_EN
  ,
  output logic              rsp_perr
`endif
);

`ifdef IMEM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  typedef enum logic {ST_LOAD, ST_RUN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [MEM_W-1:0]  r_mem [DEPTH];
  logic [DATA_W-1:0] r_ent_data [2];
  logic [ADDR_W-1:0] r_ent_addr [2];
  logic              r_ent_oob  [2];
  logic [1:0]        r_cnt;
  logic              r_wr_ptr;
  logic              r_rd_ptr;

  logic              w_wr_in;
  logic              w_req_in;
  logic              w_push;
  logic              w_pop;
  logic [MEM_W-1:0]  w_wr_word;
  logic [MEM_W-1:0]  w_rd_word;

  assign w_wr_in  = {1'b0, wr_addr}  < LP_DEPTH;
  assign w_req_in = {1'b0, req_addr} < LP_DEPTH;

`ifdef IMEM_PARITY_EN
  assign w_wr_word = {^wr_data, wr_data};
`else
  assign w_wr_word = wr_data;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_LOAD;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD: if (start && !halt) w_state_nxt = ST_RUN;
      ST_RUN:  if (halt)           w_state_nxt = ST_LOAD;
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  assign mode_run  = (r_state == ST_RUN);
  assign req_ready = mode_run && (r_cnt != 2'd2);
  assign rsp_valid = (r_cnt != 2'd0);

  // A halt edge discards any push that would otherwise land in the same cycle.
  assign w_push = req_valid && req_ready && !halt;
  assign w_pop  = rsp_valid && rsp_ready;

  // Memory is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clock) begin
    if (r_state == ST_LOAD && wr_en && w_wr_in) r_mem[wr_addr] <= w_wr_word;
  end

  always_comb begin
    w_rd_word = '0;
    if (w_req_in) w_rd_word = r_mem[req_addr];
  end

`ifdef IMEM_PARITY_EN
  logic r_ent_par [2];
  always_ff @(posedge clock) begin
    if (w_push) r_ent_par[r_wr_ptr] <= w_rd_word[DATA_W];
  end
  assign rsp_perr = rsp_valid && !r_ent_oob[r_rd_ptr] &&
                    ((^r_ent_data[r_rd_ptr]) != r_ent_par[r_rd_ptr]);
`endif

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_ent_data[r_wr_ptr] <= w_rd_word[DATA_W-1:0];
      r_ent_addr[r_wr_ptr] <= req_addr;
      r_ent_oob[r_wr_ptr]  <= !w_req_in;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else if (halt) begin
      r_cnt    <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign rsp_data = rsp_valid ? r_ent_data[r_rd_ptr] : '0;
  assign rsp_addr = rsp_valid ? r_ent_addr[r_rd_ptr] : '0;
  assign rsp_oob  = rsp_valid && r_ent_oob[r_rd_ptr];

endmodule
